// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl_if
// Purpose  : Fetch-to-decode handshake bundle carried between the
//            instruction-fetch sequencer and the IF/ID pipeline register.
// Signals  : if_valid  - queue head valid           (fetch -> decode)
//            if_instr  - queue head instruction     (fetch -> decode)
//            if_pc     - byte PC of queue head      (fetch -> decode)
//            id_ready  - decode accepts head        (decode -> fetch)
// Modports : master (fetch side), slave (decode side)
// Revision : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if #(
   parameter int N    = 32,
   parameter int PC_W = 64
);
   logic            if_valid;
   logic [N-1:0]    if_instr;
   logic [PC_W-1:0] if_pc;
   logic            id_ready;

   modport master (
      output if_valid,
      output if_instr,
      output if_pc,
      input  id_ready
   );

   modport slave (
      input  if_valid,
      input  if_instr,
      input  if_pc,
      output id_ready
   );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction-fetch sequencer for a single-cycle-read instruction
//            ROM. Owns the PC, drives the ROM word address, buffers fetched
//            words in a 2-entry FIFO toward decode (valid/ready), applies
//            branch redirects with flush, and stops at end of program.
// Ports    : clk         - clock, rising edge
//            reset       - synchronous, active-low reset
//            start       - 1-cycle pulse, leave IDLE and begin fetching
//            imem_addr   - ROM word address (pc[9:2])
//            imem_q      - ROM read data for imem_addr (same cycle)
//            br_taken    - redirect request from EX/MEM
//            br_target   - redirect byte address
//            fq          - fetch/decode handshake (master modport)
//            done        - program finished and queue drained
//            fault       - sticky misaligned-redirect indication
//            fetch_count - words enqueued since reset, saturating
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
   parameter int              N         = 32,
   parameter int              PC_W      = 64,
   parameter int              MEM_WORDS = 171,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              start,
   output logic [7:0]             imem_addr,
   input  wire logic [N-1:0]      imem_q,
   input  wire logic              br_taken,
   input  wire logic [PC_W-1:0]   br_target,
   imem_fetch_ctrl_if.master      fq,
   output logic                   done,
   output logic                   fault,
   output logic [15:0]            fetch_count
);

   // First byte address past the program; compared against the full PC so
   // that addresses beyond the 8-bit ROM window never alias back into it.
   localparam logic [PC_W-1:0] c_pc_end = PC_W'(MEM_WORDS * 4);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [1:0]      r_count;
   logic [N-1:0]    r_q_instr [2];
   logic [PC_W-1:0] r_q_pc    [2];
   logic [15:0]     r_fetch_count;

   logic            w_pc_in_range;
   logic            w_tgt_in_range;
   logic            w_tgt_misaligned;
   logic            w_push;
   logic            w_pop;
   logic            w_flush;
   logic            w_load_pc;

   assign w_pc_in_range    = (r_pc < c_pc_end);
   assign w_tgt_in_range   = (br_target < c_pc_end);
   assign w_tgt_misaligned = (br_target[1:0] != 2'b00);

   // ------------------------------------------------------------------------
   // Next-state and datapath control
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
      w_load_pc   = 1'b0;

      // A redirect kills the head offered this cycle, so it never pops.
      if (r_state != S_FAULT) begin
         w_pop   = (r_count != 2'd0) && fq.id_ready && !br_taken;
         w_flush = br_taken;
      end

      case (r_state)
         S_IDLE: begin
            if (br_taken) begin
               if (w_tgt_misaligned) w_state_nxt = S_FAULT;
               else                  w_load_pc   = 1'b1;
            end else if (start) begin
               w_state_nxt = w_pc_in_range ? S_FETCH : S_DONE;
            end
         end
         S_FETCH: begin
            if (br_taken) begin
               // An out-of-range aligned target is caught by the range
               // check on the following cycle, before any fetch from it.
               if (w_tgt_misaligned) w_state_nxt = S_FAULT;
               else                  w_load_pc   = 1'b1;
            end else if (!w_pc_in_range) begin
               w_state_nxt = S_DONE;
            end else begin
               w_push = (r_count != 2'd2) || w_pop;
            end
         end
         S_DONE: begin
            if (br_taken) begin
               if (w_tgt_misaligned) begin
                  w_state_nxt = S_FAULT;
               end else begin
                  w_load_pc = 1'b1;
                  if (w_tgt_in_range) w_state_nxt = S_FETCH;
               end
            end
         end
         S_FAULT: begin
            // Only reset leaves FAULT; PC and queue stay frozen.
         end
         default: w_state_nxt = S_FAULT;
      endcase
   end

   // ------------------------------------------------------------------------
   // State, PC and counter registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_fetch_count <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_pc)   r_pc <= br_target;
         else if (w_push) r_pc <= r_pc + PC_W'(4);
         if (w_push && (r_fetch_count != 16'hFFFF))
            r_fetch_count <= r_fetch_count + 16'd1;
      end
   end

   // ------------------------------------------------------------------------
   // 2-entry FIFO, head always in entry 0. Entries are not cleared on flush
   // so the head outputs hold their last value while the queue is empty.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count      <= 2'd0;
         r_q_instr[0] <= '0;
         r_q_instr[1] <= '0;
         r_q_pc[0]    <= '0;
         r_q_pc[1]    <= '0;
      end else if (w_flush) begin
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_q_instr[0] <= imem_q;
                  r_q_pc[0]    <= r_pc;
               end else begin
                  r_q_instr[1] <= imem_q;
                  r_q_pc[1]    <= r_pc;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_q_instr[0] <= r_q_instr[1];
               r_q_pc[0]    <= r_q_pc[1];
               r_count      <= r_count - 2'd1;
            end
            2'b11: begin
               // Pop needs a valid head, so count is 1 or 2 here.
               if (r_count == 2'd1) begin
                  r_q_instr[0] <= imem_q;
                  r_q_pc[0]    <= r_pc;
               end else begin
                  r_q_instr[0] <= r_q_instr[1];
                  r_q_pc[0]    <= r_q_pc[1];
                  r_q_instr[1] <= imem_q;
                  r_q_pc[1]    <= r_pc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign imem_addr   = r_pc[9:2];
   assign fq.if_valid = (r_count != 2'd0);
   assign fq.if_instr = r_q_instr[0];
   assign fq.if_pc    = r_q_pc[0];
   assign done        = (r_state == S_DONE) && (r_count == 2'd0);
   assign fault       = (r_state == S_FAULT);
   assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Directed self-checking bench for imem_fetch_ctrl with a
//            combinational ROM model and hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  imem_addr;
   logic [31:0] imem_q;
   logic        br_taken;
   logic [63:0] br_target;
   logic        done;
   logic        fault;
   logic [15:0] fetch_count;

   logic [31:0] rom [256];

   int checks = 0;
   int errors = 0;

   imem_fetch_ctrl_if #(.N(32), .PC_W(64)) fq ();

   imem_fetch_ctrl #(
      .N(32), .PC_W(64), .MEM_WORDS(171), .RESET_PC(64'd0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .imem_addr   (imem_addr),
      .imem_q      (imem_q),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .fq          (fq.master),
      .done        (done),
      .fault       (fault),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   assign imem_q = rom[imem_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, {63'd0, fq.if_valid}, 64'd0);
      chk({tag, "_instr"}, {32'd0, fq.if_instr}, 64'd0);
      chk({tag, "_pc"},    fq.if_pc, 64'd0);
      chk({tag, "_done"},  {63'd0, done}, 64'd0);
      chk({tag, "_fault"}, {63'd0, fault}, 64'd0);
      chk({tag, "_fcnt"},  {48'd0, fetch_count}, 64'd0);
      chk({tag, "_addr"},  {56'd0, imem_addr}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] exp_pc;
      logic [63:0] last_pc;

      for (int i = 0; i < 256; i++) rom[i] = 32'hA500_0000 + i;
      rom[0] = 32'hf800_0001;
      rom[1] = 32'hf800_8002;
      rom[2] = 32'hf800_0203;

      reset = 1'b0; start = 1'b0; br_taken = 1'b0; br_target = '0;
      fq.id_ready = 1'b1;

      // ---------------- T1: reset, start, in-order delivery ----------------
      tick(); tick();
      chk_reset_outputs("t1_rst");
      reset = 1'b1;
      tick();
      chk("t1_idle_valid", {63'd0, fq.if_valid}, 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_lat_valid", {63'd0, fq.if_valid}, 64'd0);
      chk("t1_addr0", {56'd0, imem_addr}, 64'd0);
      tick();
      chk("t1_v0", {63'd0, fq.if_valid}, 64'd1);
      chk("t1_pc0", fq.if_pc, 64'h0);
      chk("t1_i0", {32'd0, fq.if_instr}, 64'hf8000001);
      tick();
      chk("t1_pc1", fq.if_pc, 64'h4);
      chk("t1_i1", {32'd0, fq.if_instr}, 64'hf8008002);
      tick();
      chk("t1_pc2", fq.if_pc, 64'h8);
      chk("t1_i2", {32'd0, fq.if_instr}, 64'hf8000203);
      chk("t1_fcnt", {48'd0, fetch_count}, 64'd3);

      // ---------------- T2: backpressure stall ----------------
      reset = 1'b0; tick(); tick(); reset = 1'b1;
      fq.id_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("t2_addr_stall", {56'd0, imem_addr}, 64'd2);
      chk("t2_fcnt", {48'd0, fetch_count}, 64'd2);
      chk("t2_head", fq.if_pc, 64'h0);
      fq.id_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("t2_valid", {63'd0, fq.if_valid}, 64'd1);
         chk("t2_pc", fq.if_pc, 64'(4 * k));
         chk("t2_instr", {32'd0, fq.if_instr}, {32'd0, rom[k]});
         tick();
      end

      // ---------------- T3: redirect with full queue ----------------
      fq.id_ready = 1'b0;
      tick(); tick();
      br_taken = 1'b1; br_target = 64'h40; fq.id_ready = 1'b1;
      tick();
      br_taken = 1'b0;
      chk("t3_flush_valid", {63'd0, fq.if_valid}, 64'd0);
      chk("t3_addr", {56'd0, imem_addr}, 64'd16);
      tick();
      chk("t3_valid", {63'd0, fq.if_valid}, 64'd1);
      chk("t3_pc", fq.if_pc, 64'h40);
      chk("t3_instr", {32'd0, fq.if_instr}, {32'd0, rom[16]});
      tick();
      chk("t3_pc_next", fq.if_pc, 64'h44);

      // ---------------- T4: run to end of program ----------------
      exp_pc = 64'h44;
      last_pc = '0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (fq.if_valid) begin
            chk("t4_pc", fq.if_pc, exp_pc);
            last_pc = fq.if_pc;
            exp_pc  = exp_pc + 64'd4;
         end
         tick();
      end
      chk("t4_done", {63'd0, done}, 64'd1);
      chk("t4_last_pc", last_pc, 64'h2A8);
      chk("t4_valid_end", {63'd0, fq.if_valid}, 64'd0);
      br_taken = 1'b1; br_target = 64'h10;
      tick();
      br_taken = 1'b0;
      chk("t4_resume_done", {63'd0, done}, 64'd0);
      tick();
      chk("t4_resume_pc", fq.if_pc, 64'h10);
      chk("t4_resume_instr", {32'd0, fq.if_instr}, {32'd0, rom[4]});

      // ---------------- T5: misaligned redirect -> FAULT ----------------
      br_taken = 1'b1; br_target = 64'h42;
      tick();
      br_taken = 1'b0;
      chk("t5_fault", {63'd0, fault}, 64'd1);
      chk("t5_valid", {63'd0, fq.if_valid}, 64'd0);
      chk("t5_addr", {56'd0, imem_addr}, 64'd5);
      br_taken = 1'b1; br_target = 64'h10;
      tick();
      br_taken = 1'b0;
      tick();
      chk("t5_sticky", {63'd0, fault}, 64'd1);
      chk("t5_addr_frozen", {56'd0, imem_addr}, 64'd5);
      chk("t5_done", {63'd0, done}, 64'd0);
      reset = 1'b0; tick(); reset = 1'b1;
      chk_reset_outputs("t5_rst");
      tick();
      chk("t5_idle_valid", {63'd0, fq.if_valid}, 64'd0);

      // ---------------- T6: aliasing target, mid-FETCH reset ----------------
      start = 1'b1; tick(); start = 1'b0;
      tick();
      br_taken = 1'b1; br_target = 64'h400;
      tick();
      br_taken = 1'b0;
      chk("t6_flush_valid", {63'd0, fq.if_valid}, 64'd0);
      chk("t6_alias_addr", {56'd0, imem_addr}, 64'd0);
      tick();
      chk("t6_done", {63'd0, done}, 64'd1);
      chk("t6_no_fetch", {48'd0, fetch_count}, 64'd1);
      tick();
      chk("t6_still_empty", {63'd0, fq.if_valid}, 64'd0);
      br_taken = 1'b1; br_target = 64'h20;
      tick();
      br_taken = 1'b0;
      tick(); tick();
      chk("t6_refetch_pc", fq.if_pc, 64'h24);
      reset = 1'b0; tick(); reset = 1'b1;
      chk_reset_outputs("t6_rst");
      start = 1'b1; tick(); start = 1'b0;
      tick();
      chk("t6_restart_pc", fq.if_pc, 64'h0);
      chk("t6_restart_instr", {32'd0, fq.if_instr}, 64'hf8000001);
      chk("t6_restart_fcnt", {48'd0, fetch_count}, 64'd1);

      // Redirect while IDLE only moves the PC.
      reset = 1'b0; tick(); reset = 1'b1;
      br_taken = 1'b1; br_target = 64'h8;
      tick();
      br_taken = 1'b0;
      chk("t6_idle_br_addr", {56'd0, imem_addr}, 64'd2);
      chk("t6_idle_br_valid", {63'd0, fq.if_valid}, 64'd0);
      start = 1'b1; tick(); start = 1'b0;
      tick();
      chk("t6_idle_br_pc", fq.if_pc, 64'h8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
